// File: rtl/quad_encoder_counter.sv
// Bank of x4 quadrature-encoder position counters with per-channel glitch filter,
// PIO-driven count clear, sticky illegal-transition flags and an Avalon-MM read port.
module quad_encoder_counter #(
  parameter int NUM_CH     = 4,
  parameter int FILTER_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] quad_a,
  input  logic [NUM_CH-1:0] quad_b,
  input  logic [31:0]       cnt_reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata
);

  localparam logic [3:0] RUN_ACCEPT = 4'(FILTER_LEN - 1);
  localparam logic [3:0] RUN_FULL   = 4'(FILTER_LEN);
  localparam logic [2:0] ERR_ADDR   = 3'd4;

  logic [31:0]       count [NUM_CH];
  logic [NUM_CH-1:0] err;
  logic              err_wr;
  logic              unused_bits;

  assign err_wr      = chipselect && !write_n && (address == ERR_ADDR);
  assign unused_bits = ^{cnt_reset[31:NUM_CH], writedata[31:NUM_CH]};

  // Forward (A leads B) successor of an {A,B} state: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  cand;
    logic [1:0]  filt;
    logic [3:0]  run;
    logic [31:0] pos;
    logic        err_q;
    logic        accept;
    logic        step_fwd;
    logic        step_rev;
    logic        illegal;
    logic        err_clr;

    // NOTE: every register here uses non-blocking assignment so all stages
    // sample their inputs from before the edge, giving a true shift pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1 <= 2'b00;
        sync2 <= 2'b00;
      end else begin
        sync1 <= {quad_a[g], quad_b[g]};
        sync2 <= sync1;
      end
    end

    // A new level is accepted only once it has been stable for FILTER_LEN samples.
    assign accept = (sync2 == cand) && (run == RUN_ACCEPT) && (sync2 != filt);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cand <= 2'b00;
        run  <= 4'd0;
        filt <= 2'b00;
      end else if (sync2 != cand) begin
        cand <= sync2;
        run  <= 4'd1;
      end else if (accept) begin
        filt <= sync2;
        run  <= RUN_FULL;
      end else if (run < RUN_FULL) begin
        run <= run + 4'd1;
      end
    end

    assign step_fwd = accept && (sync2 == fwd_next(filt));
    assign step_rev = accept && (sync2 == rev_next(filt));
    assign illegal  = accept && ((sync2 ^ filt) == 2'b11);
    assign err_clr  = err_wr && writedata[g];

    // The PIO clear outranks a step on the same edge; the filter is left running.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos <= 32'd0;
      end else if (cnt_reset[g]) begin
        pos <= 32'd0;
      end else if (step_fwd) begin
        pos <= pos + 32'd1;
      end else if (step_rev) begin
        pos <= pos - 32'd1;
      end
    end

    // A new illegal transition wins over a simultaneous software clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        err_q <= 1'b0;
      end else begin
        err_q <= illegal | (err_q & ~err_clr);
      end
    end

    assign count[g] = pos;
    assign err[g]   = err_q;
  end

  // NOTE: readdata gets a default before any branch so the read mux stays
  // purely combinational with no inferred latch.
  always_comb begin
    readdata = 32'd0;
    if (chipselect) begin
      if (address == ERR_ADDR) begin
        readdata[NUM_CH-1:0] = err;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == 3'(i)) begin
            readdata = count[i];
          end
        end
      end
    end
  end

endmodule

// File: doc/quad_encoder_counter.md
# quad_encoder_counter

Bank of quadrature-encoder position counters for the robot's axis motors, sitting directly downstream of the HPS-controlled quadrature-reset PIO. Each channel synchronises and glitch-filters its encoder A/B pair, decodes x4 quadrature steps into a 32-bit signed position, and clears on the matching bit of the PIO's 32-bit output word. Positions and sticky error flags are read by the HPS over an Avalon-MM slave.

## Interface
- NUM_CH, 4: number of encoder channels, 1..4.
- FILTER_LEN, 4: consecutive identical samples required to accept a new A/B state, 2..15.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- quad_a  in  NUM_CH  encoder A phase per channel, asynchronous to clk.
- quad_b  in  NUM_CH  encoder B phase per channel, asynchronous to clk.
- cnt_reset  in  32  reset word from the quad-reset PIO; bit i clears channel i; bits NUM_CH..31 ignored.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.

## Operation
- Per channel, pipeline: 2-FF synchroniser (sync1, sync2) on {A,B} -> joint 2-bit filter -> decoder -> 32-bit counter.
- Filter state: cand[1:0], run[3:0], filt[1:0].
  - If sync2 != cand: cand <= sync2, run <= 1.
  - Else if run == FILTER_LEN-1 and sync2 != filt: filt <= sync2, run <= FILTER_LEN.
  - Else if run < FILTER_LEN: run <= run+1.
  - A level held for fewer than FILTER_LEN clocks never reaches filt.
- Decode, evaluated on the edge where filt accepts a new value, using old filt -> new filt:
  - +1: 00->10, 10->11, 11->01, 01->00 (A leads B).
  - -1: the reverse sequence.
  - Both bits changing is illegal: no count change; err[i] <= 1.
- Counter: 32-bit two's complement. +1 from 0x7FFFFFFF gives 0x80000000. -1 from 0 gives 0xFFFFFFFF. No saturation.
- cnt_reset[i] is level-sensitive, same clock domain, not resynchronised. While high, count[i] <= 0 every cycle and decoded steps are discarded. The filter keeps running, so filt stays current and no false step occurs on release. Reset has priority over a step in the same cycle.
- err[i] is sticky. A write to address 4 with writedata[i]=1 clears err[i]. If a set and a clear coincide in the same cycle, the set wins. cnt_reset does not touch err.
- Register map, read:
  - Address 0..NUM_CH-1 returns count[address].
  - Address 4 returns {28'b0, err[3:0]}, with unused channel bits reading 0.
  - Other addresses return 0.
  - readdata = 0 when chipselect is low.
- Writes to any address other than 4 are ignored. Counts are read-only.

## Timing
- Async reset values:
  - sync1, sync2, cand, filt = 00.
  - run = 0.
  - count = 0.
  - err = 0.
  - readdata = 0.
- Latency: a new A/B level first captured into sync1 at edge k appears in sync2 at k+1 and cand at k+2, is accepted into filt at k+FILTER_LEN+1, and count updates on that same edge. readdata reflects the new count combinationally thereafter.
- After reset deassertion, encoder inputs sitting at a non-00 level are accepted via the filter path and may produce one step or error. Firmware must pulse cnt_reset after boot; this is a decided behaviour, not a bug.
- Reset asserted mid-filter clears all state immediately; no partial step survives.
- cnt_reset takes effect on the first edge on which it is sampled high; count reads 0 from that edge onward.

## Test plan
- Reset, then 8 forward x4 steps on ch0, each level held 10 clocks -> count0 = 8, err = 0. Count changes exactly FILTER_LEN+1 edges after the sync1 capture.
- 3 reverse steps on ch1 starting from 0 -> count1 = 0xFFFFFFFD. Continue forward 3 steps -> count1 = 0.
- Glitch of FILTER_LEN-1 clocks on ch2 A -> count2 and err unchanged. Glitch of FILTER_LEN clocks -> one step.
- Flip A and B simultaneously on ch3 -> count3 unchanged, read addr 4 = 0x8. Write 0x8 to addr 4 -> reads 0. Set and clear in the same cycle -> reads 0x8.
- Preload ch0 to 0x7FFFFFFF by steps, then 1 forward step -> 0x80000000. Assert cnt_reset = 0x1 during an accepting step -> count0 = 0. Release -> no spurious step.
- cnt_reset = 0xFFFFFFF0 -> no channel affected. Read addr 5 -> 0. chipselect low -> readdata = 0.
